// File: rtl/write_enable_seq.sv
// Write-enable sequencer: turns a destination select code into a one-cycle
// one-hot register write enable, a multi-cycle memory write strobe, or a
// sticky error flag for codes that map to nothing.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  write request present
//   req_sel    destination code (0..NUM_DEST-1 register, all-ones memory)
//   req_ready  request can be accepted this cycle (state decode only)
//   we         registered one-hot register write enables
//   mem_write  registered memory write strobe, high for MEM_HOLD cycles
//   busy       memory write in progress (mirrors mem_write)
//   err        sticky invalid-code flag
//   err_clr    synchronous clear for err (a coincident new error wins)
module write_enable_seq #(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned NUM_DEST = 7,
  parameter int unsigned MEM_HOLD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [SEL_W-1:0]    req_sel,
  output logic                req_ready,
  output logic [NUM_DEST-1:0] we,
  output logic                mem_write,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  localparam int unsigned CNT_W = 4;

  localparam logic [SEL_W-1:0] MEM_CODE = '1;
  localparam logic [SEL_W-1:0] DEST_LIM = SEL_W'(NUM_DEST);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REG_WR = 2'd1,
    MEM_WR = 2'd2
  } state_t;

  state_t              state,     state_d;
  logic [NUM_DEST-1:0] we_d;
  logic                mem_d;
  logic                err_d;
  logic [CNT_W-1:0]    cnt,       cnt_d;

  // Ready depends on the state register alone, so no combinational path
  // from the request inputs reaches it.
  assign req_ready = (state != MEM_WR);
  assign busy      = mem_write;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    we_d    = '0;
    mem_d   = 1'b0;
    cnt_d   = cnt;
    err_d   = err_clr ? 1'b0 : err;

    case (state)
      MEM_WR: begin
        // Counter holds the number of strobe cycles still to come.
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
          mem_d = 1'b1;
        end
      end
      default: begin
        // IDLE and REG_WR are both ready, so req_valid alone means accept.
        state_d = IDLE;
        if (req_valid) begin
          if (req_sel < DEST_LIM) begin
            state_d = REG_WR;
            we_d    = NUM_DEST'(1) << req_sel;
          end else if (req_sel == MEM_CODE) begin
            state_d = MEM_WR;
            mem_d   = 1'b1;
            cnt_d   = CNT_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we        <= '0;
      mem_write <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      we        <= we_d;
      mem_write <= mem_d;
      err       <= err_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_write_enable_seq.sv
module tb_write_enable_seq;

  localparam int unsigned HOLD_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // DUT A: default parameters
  logic       rst_a, a_valid, a_clr, a_ready, a_mem, a_busy, a_err;
  logic [2:0] a_sel;
  logic [6:0] a_we;

  // DUT B: NUM_DEST=5, MEM_HOLD=4
  logic       rst_b, b_valid, b_clr, b_ready, b_mem, b_busy, b_err;
  logic [2:0] b_sel;
  logic [4:0] b_we;

  write_enable_seq dut_a (
    .clk(clk), .rst_n(rst_a), .req_valid(a_valid), .req_sel(a_sel),
    .req_ready(a_ready), .we(a_we), .mem_write(a_mem), .busy(a_busy),
    .err(a_err), .err_clr(a_clr)
  );

  write_enable_seq #(.SEL_W(3), .NUM_DEST(5), .MEM_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .req_valid(b_valid), .req_sel(b_sel),
    .req_ready(b_ready), .we(b_we), .mem_write(b_mem), .busy(b_busy),
    .err(b_err), .err_clr(b_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    a_valid = 1'b1; a_sel = 3'd5; a_clr = 1'b0;
    b_valid = 1'b0; b_sel = 3'd0; b_clr = 1'b0;
    step(); step();
    tests++;
    if (a_we !== 7'd0 || a_mem !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0 || a_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_a: we=%b mem=%b busy=%b err=%b ready=%b, need 0/0/0/0/1", a_we, a_mem, a_busy, a_err, a_ready);
    end
    tests++;
    if (b_we !== 5'd0 || b_mem !== 1'b0 || b_err !== 1'b0 || b_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_b: we=%b mem=%b err=%b ready=%b, need 0/0/0/1", b_we, b_mem, b_err, b_ready);
    end
    // release with a request already waiting: first edge accepts it
    rst_a = 1'b1; rst_b = 1'b1;
    step();
    tests++;
    if (a_we !== 7'b0100000) begin
      failed++;
      $display("FAIL first_accept: we=%b, need 0100000", a_we);
    end
    a_valid = 1'b0;
    step();
    tests++;
    if (a_we !== 7'd0) begin
      failed++;
      $display("FAIL first_accept_idle: we=%b, need 0000000", a_we);
    end
  endtask

  task automatic test_single_reg();
    a_valid = 1'b1; a_sel = 3'd3;
    step();
    a_valid = 1'b0;
    tests++;
    if (a_we !== 7'b0001000 || a_mem !== 1'b0) begin
      failed++;
      $display("FAIL single_reg: we=%b mem=%b, need 0001000/0", a_we, a_mem);
    end
    step();
    tests++;
    if (a_we !== 7'd0) begin
      failed++;
      $display("FAIL single_reg_end: we=%b, need 0000000", a_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] sels [3];
    logic [6:0] exp  [3];
    sels = '{3'd0, 3'd1, 3'd6};
    exp  = '{7'b0000001, 7'b0000010, 7'b1000000};
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_sel = sels[i];
      step();
      tests++;
      if (a_we !== exp[i] || a_ready !== 1'b1) begin
        failed++;
        $display("FAIL back_to_back[%0d]: we=%b ready=%b, need %b/1", i, a_we, a_ready, exp[i]);
      end
    end
    a_valid = 1'b0;
    step();
    tests++;
    if (a_we !== 7'd0) begin
      failed++;
      $display("FAIL back_to_back_end: we=%b, need 0000000", a_we);
    end
  endtask

  task automatic test_mem_write();
    a_valid = 1'b1; a_sel = 3'd7;
    step();
    a_sel = 3'd2;  // held during the hold; taken once ready returns
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (a_mem !== 1'b1 || a_busy !== 1'b1 || a_ready !== 1'b0 || a_we !== 7'd0) begin
        failed++;
        $display("FAIL mem_hold[%0d]: mem=%b busy=%b ready=%b we=%b, need 1/1/0/0", i, a_mem, a_busy, a_ready, a_we);
      end
      step();
    end
    tests++;
    if (a_mem !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_we !== 7'd0) begin
      failed++;
      $display("FAIL mem_done: mem=%b busy=%b ready=%b we=%b, need 0/0/1/0", a_mem, a_busy, a_ready, a_we);
    end
    step();
    a_valid = 1'b0;
    tests++;
    if (a_we !== 7'b0000100 || a_mem !== 1'b0) begin
      failed++;
      $display("FAIL mem_then_reg: we=%b mem=%b, need 0000100/0", a_we, a_mem);
    end
    step();
  endtask

  task automatic test_invalid();
    b_valid = 1'b1; b_sel = 3'd5;
    step();
    tests++;
    if (b_we !== 5'd0 || b_mem !== 1'b0 || b_err !== 1'b1 || b_ready !== 1'b1) begin
      failed++;
      $display("FAIL invalid_set: we=%b mem=%b err=%b ready=%b, need 0/0/1/1", b_we, b_mem, b_err, b_ready);
    end
    b_sel = 3'd6; b_clr = 1'b1;
    step();
    tests++;
    if (b_err !== 1'b1 || b_we !== 5'd0) begin
      failed++;
      $display("FAIL invalid_set_wins: err=%b we=%b, need 1/0", b_err, b_we);
    end
    b_valid = 1'b0;
    step();
    b_clr = 1'b0;
    tests++;
    if (b_err !== 1'b0) begin
      failed++;
      $display("FAIL invalid_clear: err=%b, need 0", b_err);
    end
    step();
    tests++;
    if (b_err !== 1'b0) begin
      failed++;
      $display("FAIL invalid_stays_clear: err=%b, need 0", b_err);
    end
  endtask

  task automatic test_reset_mid_hold();
    b_valid = 1'b1; b_sel = 3'd7;
    step();
    b_valid = 1'b0;
    tests++;
    if (b_mem !== 1'b1 || b_ready !== 1'b0) begin
      failed++;
      $display("FAIL hold4_first: mem=%b ready=%b, need 1/0", b_mem, b_ready);
    end
    step();  // second strobe cycle
    rst_b = 1'b0;
    #1;
    tests++;
    if (b_mem !== 1'b0 || b_busy !== 1'b0 || b_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_abort: mem=%b busy=%b ready=%b, need 0/0/1", b_mem, b_busy, b_ready);
    end
    step();
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (b_mem !== 1'b0 || b_we !== 5'd0) begin
        failed++;
        $display("FAIL post_reset_quiet[%0d]: mem=%b we=%b, need 0/0", i, b_mem, b_we);
      end
    end
  endtask

  // Reference: m_left counts strobe cycles still to show (including the
  // current one); the block is ready exactly when nothing is left.
  task automatic test_random();
    int         m_left   = 0;
    logic [6:0] m_we     = '0;
    logic       m_err    = 1'b0;
    int         accepted = 0;
    int         pulses   = 0;
    logic       inv;
    a_valid = 1'b0; a_clr = 1'b0;
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    for (int c = 0; c < 500; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_sel   = 3'($urandom_range(0, 7));
      a_clr   = ($urandom_range(0, 9) == 0);
      tests++;
      if (a_ready !== (m_left == 0)) begin
        failed++;
        $display("FAIL rnd_ready cyc %0d: got %b need %b", c, a_ready, (m_left == 0));
      end
      inv  = 1'b0;
      m_we = '0;
      if (m_left > 0) begin
        m_left--;
      end else if (a_valid) begin
        if (a_sel < 3'd7) begin
          m_we = 7'd1 << a_sel;
          accepted++;
        end else begin
          m_left = HOLD_A;
        end
      end
      if (inv)        m_err = 1'b1;
      else if (a_clr) m_err = 1'b0;
      step();
      tests++;
      if (a_we !== m_we || a_mem !== (m_left > 0) || a_busy !== (m_left > 0) || a_err !== m_err) begin
        failed++;
        $display("FAIL rnd_out cyc %0d: we=%b mem=%b busy=%b err=%b need %b/%b/%b/%b",
                 c, a_we, a_mem, a_busy, a_err, m_we, (m_left > 0), (m_left > 0), m_err);
      end
      tests++;
      if (!$onehot0({a_we, a_mem})) begin
        failed++;
        $display("FAIL rnd_exclusive cyc %0d: we=%b mem=%b", c, a_we, a_mem);
      end
      if (a_we != 7'd0) pulses++;
    end
    a_valid = 1'b0;
    step();
    tests++;
    if (pulses !== accepted) begin
      failed++;
      $display("FAIL rnd_pulse_count: got %0d need %0d", pulses, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_single_reg();
    test_back_to_back();
    test_mem_write();
    test_invalid();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
